mux16_rr_sched: RTL and testbench
=================================

# mux16_rr_sched

Round-robin scheduler that shares the 16:1 single-bit mux channel among 16 requesters. Each cycle it decides which requester owns the channel, drives the mux's 4-bit select and enable as registered signals, and emits a one-hot grant back to the requesters. Ownership is held for a bounded burst of accepted beats, then rotated, so no requester can be starved. It sits directly in front of the mux's select and enable pins; the mux data inputs come straight from the requesters.

## Interface
- MAX_BURST, 4: maximum accepted beats per grant. Legal range 1..256. The counter width is clog2(MAX_BURST), with a minimum of 1.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request vector; bit i high means requester i wants the channel.
- out_ready  input  1  downstream accepts the mux output this cycle.
- sel  output  4  mux select, binary index of the current owner.
- en  output  1  mux enable, high only while a grant is active.
- grant  output  16  one-hot owner indication; all zeros when idle.
- busy  output  1  high while the FSM is in GRANT (same value as en).

## Operation
- State: FSM {IDLE, GRANT}, a 4-bit priority pointer ptr, and a beat counter cnt.
- A beat is accepted in a cycle when en & out_ready & req[sel] are all high.
- Arbitration function pick(ptr, req):
  - Returns the first index i with req[i]=1, scanning ptr, ptr+1, …, 15, 0, …, ptr-1 (mod 16).
  - Returns "none" if req is all zeros.
- IDLE:
  - en=0, grant=0.
  - If pick(ptr, req) yields k: next state GRANT, sel<=k, grant<=1<<k, en<=1, cnt<=0.
- GRANT, release condition: the cycle's edge releases if req[sel]==0, or if a beat is accepted while cnt==MAX_BURST-1.
- GRANT, on release:
  - ptr<=sel+1, with 15 wrapping to 0.
  - Re-arbitrate in the same edge using pick(sel+1, req).
  - If it yields k: stay in GRANT with sel<=k, grant<=1<<k, cnt<=0. This is a back-to-back handoff with no idle bubble.
  - Otherwise: go to IDLE with en<=0 and grant<=0.
- GRANT, no release: cnt increments on each accepted beat and holds otherwise.
- out_ready low stalls the count indefinitely; the grant is held.
- A lone requester is re-granted immediately after its burst. cnt restarts at 0 and ptr still advances.
- Requests from non-owners never preempt the current owner.
- sel holds its last value while in IDLE; en=0 gates the mux output.

## Timing
- All outputs are registered. There is no combinational path from req or out_ready to any output.
- Request latency: req[i] rising in IDLE at edge t gives grant/en high after edge t (visible in cycle t+1).
- Release latency:
  - req[sel] low sampled at edge t removes that owner's grant after edge t.
  - The owner's data is not counted in that cycle.
- Burst of MAX_BURST beats with out_ready held high: grant stays high for exactly MAX_BURST cycles.
- Reset:
  - rst high at edge t forces state=IDLE, ptr=0, cnt=0, sel=0, en=0, grant=0, busy=0 after edge t.
  - This applies mid-burst as well.
  - req is ignored while rst is high. The first grant can appear one cycle after rst falls.
- MAX_BURST=1: release after every accepted beat, so ownership rotates per beat.

## Test plan
- Reset mid-burst:
  - Stimulus: grant to req[3] active at cnt=2, then assert rst for one cycle.
  - Required: next cycle en=0, grant=0, sel=0. After rst drops with req[3] still high, grant=0x0008 one cycle later. ptr=0 is confirmed by a request on bit 0 winning over bit 3.
- Round-robin rotation:
  - Stimulus: req=0xFFFF, out_ready=1, MAX_BURST=4.
  - Required: owners 0,1,2,…,15,0 each hold for exactly 4 cycles. No idle cycle between owners.
- Wrap and pointer:
  - Stimulus: req=0x8001 after a grant to 15 has completed.
  - Required: next owner is 0, then 15, alternating. sel follows 0→15→0.
- Early release and stall:
  - Stimulus: owner 5 with out_ready=0 for 10 cycles, then 1 for 2 beats, then req[5] drops.
  - Required: grant held through the stall, cnt=2 at the drop, release one cycle later. The next requester ≥6 is granted with no bubble, or the FSM goes IDLE with en=0 if none.
- Single requester re-grant:
  - Stimulus: req=0x0040 constant, out_ready=1.
  - Required: grant=0x0040 and en=1 continuously. The internal cnt reset is observed every 4 beats.
- MAX_BURST=1:
  - Stimulus: req=0x0006, out_ready toggling 1/0.
  - Required: ownership alternates 1↔2 only on accepted beats. Grant is unchanged in out_ready=0 cycles.

Source files
------------

// File: rtl/mux16_rr_sched.sv
// Round-robin owner scheduler for a shared 16:1 mux channel.
// Each owner holds the channel for at most MAX_BURST beats, then ownership rotates.
module mux16_rr_sched #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        out_ready,
    output logic [3:0]  sel,
    output logic        en,
    output logic [15:0] grant,
    output logic        busy
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t           state, state_d;
    logic [3:0]       ptr, ptr_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [3:0]       sel_d;
    logic [15:0]      grant_d;
    logic             accept;
    logic             release_grant;
    logic [4:0]       pick_res;

    // First requester at or after start (circularly); bit 4 flags a hit.
    function automatic logic [4:0] pick(input logic [3:0] start, input logic [15:0] r);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign en   = (state == ST_GRANT);
    assign busy = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            cnt   <= '0;
            sel   <= '0;
            grant <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
            sel   <= sel_d;
            grant <= grant_d;
        end
    end

    // Next-state: grant from IDLE, or count beats and hand off on release.
    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        cnt_d         = cnt;
        sel_d         = sel;
        grant_d       = grant;
        accept        = 1'b0;
        release_grant = 1'b0;
        pick_res      = '0;

        case (state)
            ST_IDLE: begin
                pick_res = pick(ptr, req);
                if (pick_res[4]) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_res[3:0];
                    grant_d = 16'(1) << pick_res[3:0];
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                accept        = out_ready & req[sel];
                release_grant = ~req[sel] | (accept & (cnt == CNT_LAST));
                if (release_grant) begin
                    ptr_d    = sel + 4'd1;
                    pick_res = pick(sel + 4'd1, req);
                    cnt_d    = '0;
                    if (pick_res[4]) begin
                        sel_d   = pick_res[3:0];
                        grant_d = 16'(1) << pick_res[3:0];
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end
                end else if (accept) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Randomized + directed bench for mux16_rr_sched against an ownership-level model,
// running a MAX_BURST=4 and a MAX_BURST=1 instance side by side.
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [15:0] req_a, req_b;
    logic        rdy_a, rdy_b;
    logic [3:0]  sel_a, sel_b;
    logic        en_a, en_b, busy_a, busy_b;
    logic [15:0] grant_a, grant_b;

    mux16_rr_sched #(.MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .out_ready(rdy_a),
        .sel(sel_a), .en(en_a), .grant(grant_a), .busy(busy_a)
    );

    mux16_rr_sched #(.MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .out_ready(rdy_b),
        .sel(sel_b), .en(en_b), .grant(grant_b), .busy(busy_b)
    );

    // Ownership model: owner < 0 means idle; beats counts accepted beats of current owner.
    typedef struct packed {
        int owner;
        int ptr;
        int beats;
        int sel;
    } model_t;

    model_t m_a, m_b;
    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int first_req(input int start, input logic [15:0] r);
        for (int k = 0; k < 16; k++)
            if (r[(start + k) % 16]) return (start + k) % 16;
        return -1;
    endfunction

    function automatic model_t step(input model_t m, input logic [15:0] r, input bit rdy,
                                    input int maxb, input bit rs);
        model_t n;
        int k;
        bit acc, done;
        n = m;
        if (rs) begin
            n.owner = -1; n.ptr = 0; n.beats = 0; n.sel = 0;
            return n;
        end
        if (m.owner < 0) begin
            k = first_req(m.ptr, r);
            if (k >= 0) begin n.owner = k; n.sel = k; n.beats = 0; end
            return n;
        end
        acc  = rdy && r[m.owner];
        done = !r[m.owner] || (acc && (m.beats + 1 == maxb));
        if (done) begin
            n.ptr = (m.owner + 1) % 16;
            k = first_req(n.ptr, r);
            n.beats = 0;
            if (k >= 0) begin n.owner = k; n.sel = k; end
            else n.owner = -1;
        end else if (acc) begin
            n.beats = m.beats + 1;
        end
        return n;
    endfunction

    function automatic logic [31:0] expect_vec(input model_t m);
        logic [15:0] g;
        logic        e;
        e = (m.owner >= 0);
        g = e ? (16'(1) << m.owner) : 16'h0;
        return 32'({g, 4'(m.sel), e, e});
    endfunction

    // One clock: apply inputs, advance models, sample #1 after the edge.
    task automatic cycle(input logic [15:0] ra, input bit ya, input bit sa,
                         input logic [15:0] rb, input bit yb, input bit sb);
        req_a = ra; rdy_a = ya; rst_a = sa;
        req_b = rb; rdy_b = yb; rst_b = sb;
        m_a = step(m_a, ra, ya, 4, sa);
        m_b = step(m_b, rb, yb, 1, sb);
        @(posedge clk);
        #1;
        check_eq("dut_a outputs", 32'({grant_a, sel_a, en_a, busy_a}), expect_vec(m_a));
        check_eq("dut_b outputs", 32'({grant_b, sel_b, en_b, busy_b}), expect_vec(m_b));
        @(negedge clk);
    endtask

    logic [15:0] r_a, r_b;

    initial begin
        m_a = '0; m_b = '0;
        @(negedge clk);
        cycle(16'h0, 0, 1, 16'h0, 0, 1);
        cycle(16'hFFFF, 1, 1, 16'hFFFF, 1, 1);

        // Reset mid-burst on owner 3, then bit 0 must beat bit 3.
        for (int i = 0; i < 3; i++) cycle(16'h0008, 1, 0, 16'h0006, i[0], 0);
        cycle(16'h0008, 1, 1, 16'h0006, 0, 1);
        check_eq("reset clears grant", 32'(grant_a), 32'h0);
        check_eq("reset clears sel", 32'(sel_a), 32'h0);
        cycle(16'h0008, 1, 0, 16'h0006, 1, 0);
        check_eq("regrant after reset", 32'(grant_a), 32'h0008);
        cycle(16'h0008, 1, 1, 16'h0006, 0, 0);
        cycle(16'h0009, 1, 0, 16'h0006, 1, 0);
        check_eq("ptr zero after reset", 32'(grant_a), 32'h0001);

        // Full rotation with every requester active; B alternates 1/2 on toggling ready.
        for (int i = 0; i < 70; i++) cycle(16'hFFFF, 1, 0, 16'h0006, i[0], 0);

        // Wrap between 15 and 0.
        for (int i = 0; i < 24; i++) cycle(16'h8001, 1, 0, 16'h0006, i[0], 0);

        // Owner 5 stalled, two beats, then drop: handoff to 7, later to idle.
        cycle(16'h0, 0, 1, 16'h0006, 0, 0);
        cycle(16'h0020, 0, 0, 16'h0006, 1, 0);
        check_eq("owner 5 granted", 32'(grant_a), 32'h0020);
        for (int i = 0; i < 10; i++) cycle(16'h00A0, 0, 0, 16'h0006, i[0], 0);
        check_eq("grant held in stall", 32'(grant_a), 32'h0020);
        for (int i = 0; i < 2; i++) cycle(16'h00A0, 1, 0, 16'h0006, i[0], 0);
        cycle(16'h0080, 1, 0, 16'h0006, 1, 0);
        check_eq("handoff to 7", 32'(grant_a), 32'h0080);
        cycle(16'h0000, 1, 0, 16'h0006, 0, 0);
        check_eq("idle after drop", 32'({grant_a, en_a}), 32'h0);

        // Lone requester is continuously re-granted.
        for (int i = 0; i < 20; i++) begin
            cycle(16'h0040, 1, 0, 16'h0006, i[0], 0);
            if (i > 0) check_eq("lone owner held", 32'({grant_a, en_a}), 32'h0000_0081);
        end

        // Randomized traffic with occasional reset.
        r_a = 16'($urandom); r_b = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) r_a = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 3) == 0) r_b = 16'($urandom) & 16'($urandom);
            cycle(r_a, $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0,
                  r_b, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
